// File: rtl/btn_move_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_move_conditioner
// Purpose  : Front end of the player-movement logic. Synchronises and
//            debounces the four raw direction buttons, resolves conflicting
//            presses into a single direction and emits registered, one-hot,
//            single-cycle move pulses. Hold-to-repeat is optional.
// Config   : `define AUTO_REPEAT_EN builds the hold-to-repeat timer
//            (HOLD -> REPEAT). Without it, every accepted press or
//            direction change produces exactly one pulse.
// Ports    : clk        - system clock, all state on posedge
//            reset      - asynchronous, active-low reset
//            tick       - 1-clk time-base strobe; counters advance only on it
//            enable     - 1 = moves allowed, 0 = game frozen
//            btnU/D/L/R - raw asynchronous active-high buttons
//            btn_db     - debounced levels {R,L,D,U}
//            move_*     - 1-clk move pulses, at most one high per clk
// Revision : 1.0 - initial release
// ============================================================================
module btn_move_conditioner #(
  parameter int CNT_W          = 8,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 8,
  parameter int REPEAT_RATE    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic [3:0] btn_db,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right
);

  localparam logic [1:0] c_ST_IDLE     = 2'd0;
  localparam logic [1:0] c_ST_HOLD     = 2'd1;
`ifdef AUTO_REPEAT_EN
  localparam logic [1:0] c_ST_REPEAT   = 2'd2;
`endif
  localparam logic [1:0] c_ST_WAIT_REL = 2'd3;

  localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [3:0] w_raw;
  logic [3:0] w_db;
  logic [3:0] w_dir;
  logic       w_any;

  assign w_raw  = {btnR, btnL, btnD, btnU};
  assign btn_db = w_db;

  // --------------------------------------------------------------------------
  // Per-button synchroniser and debouncer
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             cand_q;
    logic             cand_d;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter saturates at DEBOUNCE_TICKS; it restarts only when the
    // synchronised level departs from the candidate.
    always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      db_d   = db_q;
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        cnt_d  = '0;
      end else if (tick && (cnt_q <= c_DEB_LAST)) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_DEB_LAST) begin
          db_d = cand_q;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        cand_q  <= 1'b0;
        cnt_q   <= '0;
        db_q    <= 1'b0;
      end else begin
        sync1_q <= w_raw[gi];
        sync2_q <= sync1_q;
        cand_q  <= cand_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
      end
    end

    assign w_db[gi] = db_q;
  end

  // --------------------------------------------------------------------------
  // Direction resolve: opposing buttons cancel, vertical wins over horizontal
  // --------------------------------------------------------------------------
  always_comb begin
    w_dir = 4'b0000;
    if (w_db[1] && !w_db[0]) begin
      w_dir = 4'b0010;
    end else if (w_db[0] && !w_db[1]) begin
      w_dir = 4'b0001;
    end else if (w_db[3] && !w_db[2]) begin
      w_dir = 4'b1000;
    end else if (w_db[2] && !w_db[3]) begin
      w_dir = 4'b0100;
    end
  end

  assign w_any = |w_dir;

  // --------------------------------------------------------------------------
  // Move FSM
  // --------------------------------------------------------------------------
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [3:0] dir_q;
  logic [3:0] dir_d;
  logic [3:0] move_q;
  logic [3:0] move_d;
  logic       w_dir_chg;

  assign w_dir_chg = (w_dir != dir_q);

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] c_DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [CNT_W-1:0] rpt_q;
  logic [CNT_W-1:0] rpt_d;
  logic [CNT_W-1:0] w_rpt_last;
  logic             w_rpt_hit;

  assign w_rpt_last = (state_q == c_ST_REPEAT) ? c_RATE_LAST : c_DELAY_LAST;
  assign w_rpt_hit  = tick && (rpt_q == w_rpt_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  // Repeat timing is meaningless without auto-repeat; the parameters are
  // kept so both builds share one parameter list.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= c_ST_IDLE;
      dir_q   <= 4'b0000;
      move_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      move_q  <= move_d;
    end
  end

  // Next-state logic. Freezing always wins; a button still held when the
  // freeze ends must be released before any further move is accepted.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = w_any ? c_ST_WAIT_REL : c_ST_IDLE;
    end else begin
      case (state_q)
        c_ST_IDLE: begin
          if (w_any) state_d = c_ST_HOLD;
        end
        c_ST_HOLD: begin
          if (!w_any) begin
            state_d = c_ST_IDLE;
          end else if (w_dir_chg) begin
            state_d = c_ST_HOLD;
`ifdef AUTO_REPEAT_EN
          end else if (w_rpt_hit) begin
            state_d = c_ST_REPEAT;
`endif
          end
        end
`ifdef AUTO_REPEAT_EN
        c_ST_REPEAT: begin
          if (!w_any) begin
            state_d = c_ST_IDLE;
          end else if (w_dir_chg) begin
            state_d = c_ST_HOLD;
          end
        end
`endif
        c_ST_WAIT_REL: begin
          if (!w_any) state_d = c_ST_IDLE;
        end
        default: state_d = c_ST_IDLE;
      endcase
    end
  end

  // Output / datapath logic: pulse, latched direction and repeat counter
  always_comb begin
    move_d = 4'b0000;
    dir_d  = dir_q;
`ifdef AUTO_REPEAT_EN
    rpt_d  = rpt_q;
`endif
    if (enable) begin
      case (state_q)
        c_ST_IDLE: begin
          if (w_any) begin
            move_d = w_dir;
            dir_d  = w_dir;
`ifdef AUTO_REPEAT_EN
            rpt_d  = '0;
`endif
          end
        end
`ifdef AUTO_REPEAT_EN
        c_ST_HOLD, c_ST_REPEAT: begin
`else
        c_ST_HOLD: begin
`endif
          if (w_any) begin
            if (w_dir_chg) begin
              move_d = w_dir;
              dir_d  = w_dir;
`ifdef AUTO_REPEAT_EN
              rpt_d  = '0;
            end else if (w_rpt_hit) begin
              move_d = dir_q;
              rpt_d  = '0;
            end else if (tick && (rpt_q < w_rpt_last)) begin
              rpt_d  = rpt_q + 1'b1;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign move_up    = move_q[0];
  assign move_down  = move_q[1];
  assign move_left  = move_q[2];
  assign move_right = move_q[3];

endmodule
`default_nettype wire

// File: tb/tb_btn_move_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_move_conditioner
// Purpose  : Self-checking bench for btn_move_conditioner. A timestamp-based
//            reference model predicts debounced levels and move pulses; the
//            predicted pulses go into a queue that a monitor drains whenever
//            the DUT shows a pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_move_conditioner;

  localparam int DEB  = 4;
  localparam int DLY  = 8;
  localparam int RATE = 3;
  localparam int MAXN = 20000;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       tick   = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] pad    = 4'b0000;   // {R,L,D,U}
  logic [3:0] btn_db;
  logic       mu, mdn, ml, mr;

  btn_move_conditioner #(
    .CNT_W(8), .DEBOUNCE_TICKS(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
  ) u_dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .btnU(pad[0]), .btnD(pad[1]), .btnL(pad[2]), .btnR(pad[3]),
    .btn_db(btn_db), .move_up(mu), .move_down(mdn), .move_left(ml), .move_right(mr)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [3:0] mv; } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: edge index since reset, pad samples per edge and
  // running tick totals so durations are differences of timestamps.
  int         n;
  logic [3:0] padh [0:MAXN];
  int         ps   [0:MAXN];
  logic [3:0] m_cand;
  int         m_chg [4];
  logic [3:0] m_db;
  int         m_mode;   // 0 idle, 1 held, 2 waiting for release
  logic [3:0] m_cur;
  bit         m_rep;
  int         m_ref;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, want);
    end
  endtask

  function automatic logic [3:0] resolve(input logic [3:0] d);
    if (d[1] && !d[0]) return 4'b0010;
    if (d[0] && !d[1]) return 4'b0001;
    if (d[3] && !d[2]) return 4'b1000;
    if (d[2] && !d[3]) return 4'b0100;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    n      = 0;
    ps[0]  = 0;
    padh[0] = 4'b0000;
    m_cand = 4'b0000;
    m_db   = 4'b0000;
    for (int b = 0; b < 4; b++) m_chg[b] = 0;
    m_mode = 0;
    m_cur  = 4'b0000;
    m_rep  = 1'b0;
    m_ref  = 0;
    q.delete();
  endtask

  task automatic emit(input logic [3:0] v);
    exp_t e;
    e.cyc = cyc;
    e.mv  = v;
    q.push_back(e);
  endtask

  task automatic model_step();
    logic [3:0] d;
    logic [3:0] lvl;
    if (n >= MAXN) return;
    n++;
    padh[n] = pad;
    ps[n]   = ps[n-1] + (tick ? 1 : 0);
    d = resolve(m_db);
    if (!enable) begin
      m_mode = (d != 0) ? 2 : 0;
    end else begin
      case (m_mode)
        0: if (d != 0) begin
             emit(d); m_cur = d; m_mode = 1; m_rep = 1'b0; m_ref = ps[n];
           end
        1: if (d == 0) begin
             m_mode = 0;
           end else if (d != m_cur) begin
             emit(d); m_cur = d; m_rep = 1'b0; m_ref = ps[n];
`ifdef AUTO_REPEAT_EN
           end else if (tick && (ps[n] - m_ref == (m_rep ? RATE : DLY))) begin
             emit(m_cur); m_rep = 1'b1; m_ref = ps[n];
`endif
           end
        default: if (d == 0) m_mode = 0;
      endcase
    end
    // Level seen by the debouncer at edge n is the pad sampled two edges ago.
    lvl = (n >= 3) ? padh[n-2] : 4'b0000;
    for (int b = 0; b < 4; b++) begin
      if (lvl[b] != m_cand[b]) begin
        m_cand[b] = lvl[b];
        m_chg[b]  = n;
      end
      if (ps[n] - ps[m_chg[b]] >= DEB) m_db[b] = m_cand[b];
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) model_step();
  end

  // Monitor: debounced levels every cycle, pulses against the queue.
  initial begin
    logic [3:0] mv;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      mv = {mr, ml, mdn, mu};
      chk("btn_db", {4'h0, btn_db}, {4'h0, m_db});
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("move_pulse", {4'h0, mv}, {4'h0, e.mv});
      end else if (mv !== 4'b0000) begin
        chk("unexpected_pulse", {4'h0, mv}, 8'h00);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missed_pulse", 8'h00, {4'h0, e.mv});
      end
    end
  end

  task automatic run(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int len, tmode, r;
    logic [3:0] msk;
    model_reset();
    tick   = 1'b1;
    enable = 1'b1;
    run(3);
    chk("reset_state", {btn_db, mr, ml, mdn, mu}, 8'h00);
    reset = 1'b1;
    run(5);

    // Short glitch on U is rejected.
    pad[0] = 1'b1; run(3); pad[0] = 1'b0; run(15);
    // R held 30 clk.
    pad[3] = 1'b1; run(30); pad[3] = 1'b0; run(20);
    // U+D together, then D released.
    pad[1:0] = 2'b11; run(20); pad[1] = 1'b0; run(20); pad[0] = 1'b0; run(15);
    // L held, freeze, unfreeze while held, release, press again.
    pad[2] = 1'b1; run(25); enable = 1'b0; run(5); enable = 1'b1; run(12);
    pad[2] = 1'b0; run(12); pad[2] = 1'b1; run(15); pad[2] = 1'b0; run(15);
    // Asynchronous reset while D is repeating, released with D still held.
    pad[1] = 1'b1; run(22);
    @(posedge clk); #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_reset_outputs", {btn_db, mr, ml, mdn, mu}, 8'h00);
    run(2);
    reset = 1'b1;
    run(30); pad[1] = 1'b0; run(15);

    // Randomised segments: single-button changes, bounces, sparse ticks, freezes.
    for (int s = 0; s < 130; s++) begin
      len   = $urandom_range(1, 30);
      tmode = $urandom_range(0, 2);
      r     = $urandom_range(0, 9);
      msk   = 4'b0001 << $urandom_range(0, 3);
      if (r < 6) begin
        pad = pad ^ msk;
      end else if (r < 8) begin
        repeat ($urandom_range(1, 3)) begin
          pad = pad ^ msk;
          run(1);
        end
      end
      enable = ($urandom_range(0, 9) != 0);
      repeat (len) begin
        tick = (tmode == 0) ? 1'b1 : ($urandom_range(0, tmode) == 0);
        run(1);
      end
    end

    tick = 1'b1; enable = 1'b1; pad = 4'b0000;
    run(40);
    chk("queue_drained", 8'(q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
